// File: rtl/rst_sequencer_pkg.sv
// Shared types and defaults for the PLL-lock driven reset sequencer.
package rst_sequencer_pkg;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP     = 16;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_STABLE,
    REL_CORE,
    REL_PERIPH,
    RUN
  } seq_state_t;

  typedef struct packed {
    logic rst_core;
    logic rst_periph;
    logic ready;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RST = '{rst_core: 1'b1, rst_periph: 1'b1, ready: 1'b0};

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  // Output levels owned by each state; evaluated on the next state so the
  // registered outputs move on the same edge as the state register.
  function automatic seq_out_t state_outputs(input seq_state_t s);
    seq_out_t o;
    o.rst_core   = !(s inside {REL_CORE, REL_PERIPH, RUN});
    o.rst_periph = !(s inside {REL_PERIPH, RUN});
    o.ready      = (s == RUN);
    return o;
  endfunction

endpackage

// File: rtl/rst_sequencer_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, async active-high clear.
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) ff <= '0;
    else     ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for a stable PLL lock, then releases core reset,
// peripheral reset and finally ready, with fixed latency. SYNC_STAGES >= 2.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int STAGE_GAP     = DEF_STAGE_GAP,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       sw_rst_req,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, STAGE_GAP);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

  logic             lock_s;
  seq_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             loss_evt;
  seq_out_t         out_q;

  sync_bit #(.DEPTH(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .clr (rst),
    .d   (locked),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HOLD;
      cnt           <= '0;
      out_q         <= SEQ_OUT_RST;
      lock_loss_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out_q <= state_outputs(state_n);
      if (loss_evt && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  // Lock loss outranks sw_rst_req everywhere; sw_rst_req only acts once released.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    loss_evt = 1'b0;
    case (state)
      HOLD: begin
        if (lock_s) begin
          state_n = WAIT_STABLE;
          cnt_n   = '0;
        end
      end
      WAIT_STABLE: begin
        if (!lock_s) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = REL_CORE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      REL_CORE: begin
        if (!lock_s) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else if (sw_rst_req) begin
          state_n = WAIT_STABLE;
          cnt_n   = '0;
        end else if (cnt == GAP_LAST) begin
          state_n = REL_PERIPH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      REL_PERIPH: begin
        cnt_n = '0;
        if (!lock_s)         state_n = HOLD;
        else if (sw_rst_req) state_n = WAIT_STABLE;
        else                 state_n = RUN;
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) begin
          state_n  = HOLD;
          loss_evt = 1'b1;
        end else if (sw_rst_req) begin
          state_n = WAIT_STABLE;
        end
      end
      default: begin
        state_n = HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  assign rst_core   = out_q.rst_core;
  assign rst_periph = out_q.rst_periph;
  assign ready      = out_q.ready;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output vectors are queued with
// the edge they belong to and compared on the following falling edge.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst, locked, sw_rst_req;
  logic       rst_core, rst_periph, ready;
  logic [7:0] lock_loss_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [10:0] vec;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] V_HOLD = 3'b110;
  localparam logic [2:0] V_CORE = 3'b010;
  localparam logic [2:0] V_PERI = 3'b000;
  localparam logic [2:0] V_RUN  = 3'b001;

  rst_sequencer #(.STABLE_CYCLES(8), .STAGE_GAP(4), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .sw_rst_req    (sw_rst_req),
    .rst_core      (rst_core),
    .rst_periph    (rst_periph),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {rc,rp,rdy,cnt}=%b_%0d required %b_%0d",
               tag, got[10:8], got[7:0], exp[10:8], exp[7:0]);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [2:0] o, input logic [7:0] llc);
    exp_t e;
    e.cyc = c;
    e.tag = $sformatf("%s@%0d", tag, c);
    e.vec = {o, llc};
    sb.push_back(e);
  endtask

  // Release timeline with locked set up before edge e0.
  task automatic release_from(input int e0, input logic [7:0] llc);
    push(e0 + 9,  "still_held", V_HOLD, llc);
    push(e0 + 10, "core_rel",   V_CORE, llc);
    push(e0 + 13, "gap_end",    V_CORE, llc);
    push(e0 + 14, "periph_rel", V_PERI, llc);
    push(e0 + 15, "ready",      V_RUN,  llc);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, {rst_core, rst_periph, ready, lock_loss_cnt}, sb[i].vec);
        sb.delete(i);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int n, e0;
    logic [7:0] prev, nxt;
    rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {rst_core, rst_periph, ready, lock_loss_cnt}, {V_HOLD, 8'd0});

    // Release after rst, with an ignored sw_rst_req inside WAIT_STABLE.
    n = cyc; rst = 1'b0; locked = 1'b1; e0 = n + 1;
    release_from(e0, 8'd0);
    wait_cyc(e0 + 4); sw_rst_req = 1'b1;
    wait_cyc(e0 + 5); sw_rst_req = 1'b0;
    wait_cyc(e0 + 16);

    // Lock loss in RUN, then relock.
    n = cyc; locked = 1'b0;
    push(n + 2, "loss_sync", V_RUN, 8'd0);
    push(n + 3, "loss_hold", V_HOLD, 8'd1);
    wait_cyc(n + 3); locked = 1'b1;
    release_from(n + 4, 8'd1);
    wait_cyc(n + 20);

    // Software reset in RUN.
    n = cyc; sw_rst_req = 1'b1;
    push(n + 1, "sw_assert", V_HOLD, 8'd1);
    release_from(n - 1, 8'd1);
    wait_cyc(n + 1); sw_rst_req = 1'b0;
    wait_cyc(n + 15);

    // Lock glitch after 5 WAIT_STABLE cycles restarts the count.
    n = cyc; locked = 1'b0;
    push(n + 3, "loss2_hold", V_HOLD, 8'd2);
    wait_cyc(n + 3); locked = 1'b1; e0 = n + 4;
    wait_cyc(e0 + 6); locked = 1'b0;
    wait_cyc(e0 + 7); locked = 1'b1;
    push(e0 + 10, "glitch_no_rel", V_HOLD, 8'd2);
    release_from(e0 + 8, 8'd2);
    wait_cyc(e0 + 24);

    // Lock loss and sw_rst_req on the same edge: lock loss wins and is counted.
    n = cyc; locked = 1'b0;
    wait_cyc(n + 2); sw_rst_req = 1'b1;
    push(n + 3, "both_hold", V_HOLD, 8'd3);
    wait_cyc(n + 3); sw_rst_req = 1'b0; locked = 1'b1;
    release_from(n + 4, 8'd3);
    wait_cyc(n + 20);

    // rst pulse in REL_CORE acts without a clock edge.
    n = cyc; sw_rst_req = 1'b1;
    push(n + 9, "relcore", V_CORE, 8'd3);
    wait_cyc(n + 1); sw_rst_req = 1'b0;
    wait_cyc(n + 10);
    #2 rst = 1'b1;
    #1 chk("async_rst", {rst_core, rst_periph, ready, lock_loss_cnt}, {V_HOLD, 8'd0});
    #1 rst = 1'b0;
    release_from(n + 11, 8'd0);
    wait_cyc(n + 27);

    // Saturation of the lock-loss counter.
    for (int i = 0; i < 300; i++) begin
      prev = (i > 255) ? 8'd255 : 8'(i);
      nxt  = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      n = cyc; locked = 1'b0;
      push(n + 2, "sat_run", V_RUN, prev);
      push(n + 3, "sat_hold", V_HOLD, nxt);
      wait_cyc(n + 3); locked = 1'b1;
      wait_cyc(n + 19);
    end
    chk("sat_final", {rst_core, rst_periph, ready, lock_loss_cnt}, {V_RUN, 8'd255});

    wait_cyc(cyc + 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
